// File: rtl/led_ctrl_pkg.sv
// led_ctrl_pkg
//   Shared encodings and widths for the LED pattern controller: FSM state
//   encoding, pattern mode encoding, bounce direction, reset LED value and
//   the mode/speed/LED field widths. next_mode() gives the mode-button
//   successor (0 -> 1 -> 2 -> 0).
package led_ctrl_pkg;

  localparam int MODE_W  = 2;
  localparam int SPEED_W = 2;
  localparam int LED_W   = 8;

  localparam logic [LED_W-1:0] LED_INIT = 8'h01;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_RUN   = 2'b01,
    ST_PAUSE = 2'b10
  } state_t;

  typedef enum logic [MODE_W-1:0] {
    MODE_ROL    = 2'd0,
    MODE_ROR    = 2'd1,
    MODE_BOUNCE = 2'd2
  } mode_t;

  typedef enum logic {
    DIR_LEFT  = 1'b0,
    DIR_RIGHT = 1'b1
  } dir_t;

  function automatic mode_t next_mode(input mode_t m);
    case (m)
      MODE_ROL: return MODE_ROR;
      MODE_ROR: return MODE_BOUNCE;
      default:  return MODE_ROL;
    endcase
  endfunction

endpackage

// File: rtl/btn_cond.sv
// btn_cond
//   Conditions one asynchronous, active-high push button into a single-cycle
//   press pulse: two-flop synchronizer, optional debounce, rising-edge detect.
//   Optional feature: define LED_CTRL_DEBOUNCE_EN to require the synchronized
//   level to stay changed for DB_CYCLES consecutive cycles before it is
//   accepted.
//   Ports:
//     clk   - clock
//     rst   - synchronous active-high reset
//     btn   - raw button input (asynchronous to clk)
//     press - one-cycle pulse per accepted rising edge
module btn_cond
  #(parameter int unsigned DB_CYCLES = 1_000_000)
  (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic press
);

  logic sync_p0;
  logic sync_p1;
  logic level;
  logic level_d;

`ifdef LED_CTRL_DEBOUNCE_EN
  localparam int unsigned DB_W = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;

  logic [DB_W-1:0] db_cnt;

  // Debounce: a differing synchronized sample must persist for DB_CYCLES
  // consecutive cycles; any agreeing sample restarts the count.
  always_ff @(posedge clk) begin
    if (rst) begin
      level  <= 1'b1;
      db_cnt <= '0;
    end else if (sync_p1 != level) begin
      if (db_cnt == DB_W'(DB_CYCLES - 1)) begin
        level  <= sync_p1;
        db_cnt <= '0;
      end else begin
        db_cnt <= db_cnt + 1'b1;
      end
    end else begin
      db_cnt <= '0;
    end
  end
`else
  // Debounce stable-time is only consumed when debounce is compiled in.
  logic [31:0] unused_db_cycles;
  assign unused_db_cycles = DB_CYCLES;
  assign level = sync_p1;
`endif

  // Reset parks the pipeline in the "pressed" level so a button already held
  // when reset releases never produces a pulse; a real press must first be
  // seen low after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_p0 <= 1'b1;
      sync_p1 <= 1'b1;
      level_d <= 1'b1;
      press   <= 1'b0;
    end else begin
      sync_p0 <= btn;
      sync_p1 <= sync_p0;
      level_d <= level;
      press   <= level & ~level_d;
    end
  end

endmodule

// File: rtl/led_pattern_ctrl.sv
// led_pattern_ctrl
//   Eight-LED pattern controller. Three buttons run/pause the pattern, select
//   the pattern (rotate-left, rotate-right, bounce) and select the step speed
//   (period TICK_DIV >> speed). The run FSM, tick counter and pattern register
//   live here; each button goes through its own btn_cond instance.
//   Optional feature: define LED_CTRL_DEBOUNCE_EN to debounce the buttons
//   for DB_CYCLES cycles (default build: synchronize + edge detect only).
//   Ports:
//     clk       - clock, all logic on the rising edge
//     rst       - synchronous active-high reset
//     btn_start - run/pause toggle button (async)
//     btn_mode  - pattern select button (async)
//     btn_speed - speed select button (async)
//     led       - registered one-hot LED drive
//     state     - FSM state (00 IDLE, 01 RUN, 10 PAUSE)
//     mode      - current pattern (0 rotl, 1 rotr, 2 bounce)
//     speed     - current speed index 0..3
module led_pattern_ctrl
  import led_ctrl_pkg::*;
  #(
  parameter int unsigned TICK_DIV  = 100_000_000,
  parameter int unsigned DB_CYCLES = 1_000_000
  ) (
  input  logic               clk,
  input  logic               rst,
  input  logic               btn_start,
  input  logic               btn_mode,
  input  logic               btn_speed,
  output logic [LED_W-1:0]   led,
  output logic [1:0]         state,
  output logic [MODE_W-1:0]  mode,
  output logic [SPEED_W-1:0] speed
);

  localparam int unsigned CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic start_press;
  logic mode_press;
  logic speed_press;

  state_t             state_q;
  mode_t              mode_q;
  dir_t               dir_q;
  logic [SPEED_W-1:0] speed_q;
  logic [LED_W-1:0]   led_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               step_q;

  // Terminal count for a speed index; a shifted-out period is clamped to one
  // cycle so the counter always wraps.
  function automatic logic [CNT_W-1:0] last_count(input logic [SPEED_W-1:0] spd);
    int unsigned period;
    period = TICK_DIV >> spd;
    if (period == 0) period = 1;
    return CNT_W'(period - 1);
  endfunction

  btn_cond #(.DB_CYCLES(DB_CYCLES)) u_start (
    .clk   (clk),
    .rst   (rst),
    .btn   (btn_start),
    .press (start_press)
  );

  btn_cond #(.DB_CYCLES(DB_CYCLES)) u_mode (
    .clk   (clk),
    .rst   (rst),
    .btn   (btn_mode),
    .press (mode_press)
  );

  btn_cond #(.DB_CYCLES(DB_CYCLES)) u_speed (
    .clk   (clk),
    .rst   (rst),
    .btn   (btn_speed),
    .press (speed_press)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      mode_q  <= MODE_ROL;
      dir_q   <= DIR_LEFT;
      speed_q <= '0;
      led_q   <= LED_INIT;
      cnt_q   <= '0;
      step_q  <= 1'b0;
    end else begin
      if (start_press) begin
        case (state_q)
          ST_IDLE:  state_q <= ST_RUN;
          ST_RUN:   state_q <= ST_PAUSE;
          ST_PAUSE: state_q <= ST_RUN;
          default:  state_q <= ST_IDLE;
        endcase
      end

      // Tick counter: a mode or speed press restarts the period and drops any
      // step that would otherwise be raised this cycle.
      if (mode_press || speed_press) begin
        cnt_q  <= '0;
        step_q <= 1'b0;
      end else if (state_q == ST_RUN) begin
        if (cnt_q >= last_count(speed_q)) begin
          cnt_q  <= '0;
          step_q <= 1'b1;
        end else begin
          cnt_q  <= cnt_q + 1'b1;
          step_q <= 1'b0;
        end
      end else begin
        step_q <= 1'b0;
      end

      if (speed_press) speed_q <= speed_q + 1'b1;

      // Pattern: a mode reload wins over a step landing in the same cycle.
      if (mode_press) begin
        mode_q <= next_mode(mode_q);
        led_q  <= LED_INIT;
        dir_q  <= DIR_LEFT;
      end else if (step_q) begin
        case (mode_q)
          MODE_ROL: led_q <= {led_q[LED_W-2:0], led_q[LED_W-1]};
          MODE_ROR: led_q <= {led_q[0], led_q[LED_W-1:1]};
          MODE_BOUNCE: begin
            if (dir_q == DIR_LEFT) begin
              if (led_q == 8'h80) begin
                led_q <= 8'h40;
                dir_q <= DIR_RIGHT;
              end else begin
                led_q <= led_q << 1;
              end
            end else begin
              if (led_q == 8'h01) begin
                led_q <= 8'h02;
                dir_q <= DIR_LEFT;
              end else begin
                led_q <= led_q >> 1;
              end
            end
          end
          default: led_q <= LED_INIT;
        endcase
      end
    end
  end

  assign led   = led_q;
  assign state = state_q;
  assign mode  = mode_q;
  assign speed = speed_q;

endmodule

// File: tb/tb_led_pattern_ctrl.sv
module tb_led_pattern_ctrl;

  logic       clk;
  logic       rst;
  logic       btn_start;
  logic       btn_mode;
  logic       btn_speed;
  logic [7:0] led;
  logic [1:0] state;
  logic [1:0] mode;
  logic [1:0] speed;

  int n_total = 0;
  int n_pass  = 0;

  localparam int B_START = 0;
  localparam int B_MODE  = 1;
  localparam int B_SPEED = 2;

  led_pattern_ctrl #(.TICK_DIV(8), .DB_CYCLES(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .btn_start (btn_start),
    .btn_mode  (btn_mode),
    .btn_speed (btn_speed),
    .led       (led),
    .state     (state),
    .mode      (mode),
    .speed     (speed)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %02h expected %02h", tag, got, exp);
  endtask

  task automatic set_btn(input int which, input logic v);
    case (which)
      B_START: btn_start = v;
      B_MODE:  btn_mode  = v;
      default: btn_speed = v;
    endcase
  endtask

  // Press lands on the outputs 4 edges after the drive (2 sync + 1 edge + 1).
  task automatic press(input int which);
    set_btn(which, 1'b1);
    tick(2);
    set_btn(which, 1'b0);
    tick(2);
  endtask

  logic [7:0] bounce_exp [8];

  initial begin
    bounce_exp = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h40};
    rst = 1'b1;
    btn_start = 1'b0;
    btn_mode  = 1'b0;
    btn_speed = 1'b0;
    tick(3);
    chk("rst_state", 8'(state), 8'h00);
    chk("rst_mode",  8'(mode),  8'h00);
    chk("rst_speed", 8'(speed), 8'h00);
    chk("rst_led",   led,       8'h01);
    rst = 1'b0;

`ifdef LED_CTRL_DEBOUNCE_EN
    tick(12);
    btn_start = 1'b1;
    tick(3);
    btn_start = 1'b0;
    tick(20);
    chk("db_glitch_state", 8'(state), 8'h00);
    btn_start = 1'b1;
    tick(10);
    btn_start = 1'b0;
    tick(20);
    chk("db_press_state", 8'(state), 8'h01);
    tick(30);
    chk("db_single_transition", 8'(state), 8'h01);
    chk("db_mode", 8'(mode), 8'h00);
`else
    tick(4);
    // Run: first step 9 edges after entering RUN, then every 8.
    press(B_START);
    chk("run_state", 8'(state), 8'h01);
    chk("run_led0",  led,       8'h01);
    tick(8); chk("run_before_step", led, 8'h01);
    tick(1); chk("run_step1",       led, 8'h02);
    tick(8); chk("run_step2",       led, 8'h04);

    press(B_START);
    chk("pause_state", 8'(state), 8'h02);
    chk("pause_led",   led,       8'h04);
    tick(50);
    chk("pause_hold_led",   led,       8'h04);
    chk("pause_hold_state", 8'(state), 8'h02);

    // Resume continues from the held count (5): step after 3 more edges.
    press(B_START);
    chk("resume_state", 8'(state), 8'h01);
    tick(3); chk("resume_held_cnt", led, 8'h04);
    tick(1); chk("resume_step",     led, 8'h08);

    press(B_MODE);
    chk("mode1",      8'(mode), 8'h01);
    chk("mode1_led",  led,      8'h01);
    press(B_MODE);
    chk("mode2",      8'(mode), 8'h02);
    chk("mode2_led",  led,      8'h01);
    chk("mode2_state", 8'(state), 8'h01);

    tick(9);
    chk("bounce0", led, bounce_exp[0]);
    for (int i = 1; i < 8; i++) begin
      tick(8);
      chk($sformatf("bounce%0d", i), led, bounce_exp[i]);
    end

    press(B_START);
    chk("pause2_state", 8'(state), 8'h02);
    chk("pause2_led",   led,       8'h40);
    press(B_MODE);
    chk("mode_wrap",       8'(mode),  8'h00);
    chk("mode_wrap_led",   led,       8'h01);
    chk("mode_wrap_state", 8'(state), 8'h02);

    press(B_SPEED); chk("speed1", 8'(speed), 8'h01);
    press(B_SPEED); chk("speed2", 8'(speed), 8'h02);
    press(B_SPEED); chk("speed3", 8'(speed), 8'h03);

    // Speed 3: period of one cycle, step every edge.
    press(B_START);
    chk("fast_state", 8'(state), 8'h01);
    chk("fast_led0",  led,       8'h01);
    tick(1); chk("fast_led1", led, 8'h01);
    tick(1); chk("fast_led2", led, 8'h02);
    tick(1); chk("fast_led3", led, 8'h04);
    tick(1); chk("fast_led4", led, 8'h08);
    press(B_SPEED);
    chk("speed_wrap",     8'(speed), 8'h00);
    chk("speed_wrap_led", led,       8'h80);
    tick(8); chk("slow_before_step", led, 8'h80);
    tick(1); chk("slow_step_rotl",   led, 8'h01);

    // Mode press timed to land on the same edge as the next step.
    tick(4);
    press(B_MODE);
    chk("collide_mode", 8'(mode), 8'h01);
    chk("collide_led",  led,      8'h01);
    tick(8); chk("collide_no_shift", led, 8'h01);
    tick(1); chk("rotr_step",        led, 8'h80);
    tick(24); chk("rotr_at_10",      led, 8'h10);

    rst = 1'b1;
    tick(1);
    chk("midrun_rst_led",   led,       8'h01);
    chk("midrun_rst_state", 8'(state), 8'h00);
    chk("midrun_rst_mode",  8'(mode),  8'h00);
    chk("midrun_rst_speed", 8'(speed), 8'h00);

    btn_start = 1'b1;
    tick(3);
    rst = 1'b0;
    tick(6);
    chk("press_in_rst_ignored", 8'(state), 8'h00);
    btn_start = 1'b0;
    tick(4);
    press(B_START);
    chk("press_after_rst", 8'(state), 8'h01);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
